pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Generic, parametrised pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block carrying an arbitrary-width payload. It adds a valid/ready handshake, synchronous flush and an optional two-entry skid buffer, so stages can stall independently without a combinational ready chain through the whole pipe. Each stage boundary of the core instantiates it, with the stage's control and data fields concatenated into `in_data`.

## Interface
- `WIDTH`, default 71: payload width in bits. The default is the MEM/WB bundle, 1+1+32+32+5.
- `SKID`, default 1: selects the buffering mode.
  - 1: two-entry skid buffer; `in_ready` is registered.
  - 0: single entry; `in_ready` is combinational from `out_ready`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous flush (branch/exception squash).
- `in_valid`  in  1  upstream holds a valid beat.
- `in_ready`  out  1  stage accepts a beat this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid beat.
- `out_ready`  in  1  downstream consumes the beat this cycle.
- `out_data`  out  WIDTH  payload to the next stage, driven from a register.
- `count`  out  2  occupancy: 0, 1 or 2.

## Operation
- Accept: `acc = in_valid & in_ready`.
- Consume: `pop = out_valid & out_ready`.
- Storage: main entry (`main_v`, `main_d`); with `SKID=1`, also a skid entry (`skid_v`, `skid_d`).
- `out_valid = main_v`; `out_data = main_d`.
- `in_ready`:
  - `SKID=1`: `!skid_v & !flush`.
  - `SKID=0`: `(!main_v | out_ready) & !flush`.
  - Forced to 0 while `reset` is low.
- State follows the valid bits: EMPTY (`count=0`), BUSY (`count=1`), FULL (`count=2`, `SKID=1` only).
- EMPTY: `acc` loads main and moves to BUSY; otherwise the state holds.
- BUSY:
  - `acc & pop`: load main from `in_data`; stay BUSY.
  - `acc & !pop`: with `SKID=1`, load skid and go to FULL. With `SKID=0` this case cannot occur, since `in_ready` is low.
  - `!acc & pop`: go to EMPTY.
  - Neither: hold.
- FULL:
  - `in_ready=0`.
  - `pop`: main takes `skid_d`, skid is cleared, go to BUSY.
  - No `pop`: hold. Data is never overwritten while valid.
- Flush:
  - Highest priority: clears `main_v` and `skid_v` and moves to EMPTY.
  - A beat offered in the flush cycle is not accepted, because `in_ready=0`.
  - The beat at the output in the flush cycle is still consumed if `out_ready=1`. Downstream samples it on the same edge; the flush only clears state.
- Ordering: strict FIFO. Beats leave in acceptance order and none is duplicated or lost, except on flush.

## Timing
- Reset while low, asynchronously: `main_v=0`, `skid_v=0`, `out_valid=0`, `count=0`, `out_data=0`, `in_ready=0`.
- `in_ready` rises combinationally when `reset` is released. The first accept can occur on the first rising edge after release.
- Latency: a beat accepted at edge N is on `out_data` with `out_valid=1` after edge N, i.e. 1 cycle.
- Throughput: 1 beat per cycle while `out_ready=1`, in both modes.
- Stall response with `SKID=1`: `out_ready` may drop with no same-cycle effect on `in_ready`. At most one extra beat is absorbed into skid, and `in_ready` falls the following cycle.
- Reset asserted mid-operation drops all held beats immediately, with no completion of an in-flight handshake.
- `count` is registered and updates on the same edge as the valid bits.

## Configuration
- `PIPE_STAGE_CLEAR_EN` defined:
  - On flush, and whenever an entry becomes invalid without being reloaded, that entry's data register is set to 0.
  - Consequently `out_data = 0` whenever `out_valid = 0`. Downstream may use raw control bits without gating them by valid, matching the legacy zero-bubble behaviour.
- `PIPE_STAGE_CLEAR_EN` undefined:
  - Data registers load only on accept (or skid→main transfer) and otherwise hold stale values.
  - `out_data` is don't-care when `out_valid=0`. This saves enables and power.

## Test plan
- Reset, then stream 0x1, 0x2, 0x3 on consecutive cycles with `out_ready=1` → outputs 0x1, 0x2, 0x3 on the next three cycles; `count` stays 1; `in_ready` stays 1.
- `SKID=1`: stream 0xA, 0xB, 0xC with `out_ready` held 0 from the cycle 0xA arrives → `count=2` holding 0xA and 0xB; `in_ready=0`; 0xC is held upstream. Then `out_ready=1` → outputs 0xA, 0xB, 0xC in order, with no gap.
- `SKID=0`: same stimulus → `in_ready` tracks `out_ready` in the same cycle; `count` never exceeds 1; output order is 0xA, 0xB, 0xC.
- In FULL, assert `flush` with `in_valid=1, in_data=0x55` → next cycle `count=0`, `out_valid=0`, and 0x55 never appears. With `PIPE_STAGE_CLEAR_EN` defined, `out_data=0`.
- Drop `reset` while `count=2` → `out_valid=0`, `count=0`, `out_data=0` and `in_ready=0` immediately, without a clock edge. Release → the first beat 0x7 emerges one cycle after it is accepted.
- Random `in_valid`/`out_ready` run of 10k cycles with `WIDTH=71` and `WIDTH=8` → scoreboard shows exact in-order delivery, and `count` always equals accepted minus consumed.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, synchronous flush and optional skid entry.
// Define PIPE_STAGE_CLEAR_EN to zero data registers whenever their entry goes invalid.
module pipe_stage_reg #(
  parameter int unsigned WIDTH = 71,
  parameter int unsigned SKID  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

`ifdef PIPE_STAGE_CLEAR_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif
  localparam bit SkidEn = (SKID != 0);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [1:0]       count_q, count_d;
  logic             main_v, skid_v, acc, pop;

  assign main_v = (state_q != ST_EMPTY);
  assign skid_v = (state_q == ST_FULL);

  // Skid mode decouples in_ready from out_ready; single-entry mode passes it through.
  always_comb begin
    in_ready = 1'b0;
    if (SkidEn) begin
      in_ready = ~skid_v & ~flush & reset;
    end else begin
      in_ready = (~main_v | out_ready) & ~flush & reset;
    end
  end

  assign acc = in_valid & in_ready;
  assign pop = main_v & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
      if (ClearEn) begin
        main_data_d = WIDTH'(0);
        skid_data_d = WIDTH'(0);
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_data_d = in_data;
            state_d     = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (acc && pop) begin
            main_data_d = in_data;
          end else if (acc && SkidEn) begin
            skid_data_d = in_data;
            state_d     = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
            if (ClearEn) main_data_d = WIDTH'(0);
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_data_d = skid_data_q;
            state_d     = ST_BUSY;
            if (ClearEn) skid_data_d = WIDTH'(0);
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy tracks the next state so it updates on the same edge as the valid bits.
  always_comb begin
    count_d = 2'd0;
    case (state_d)
      ST_BUSY: count_d = 2'd1;
      ST_FULL: count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= WIDTH'(0);
      skid_data_q <= WIDTH'(0);
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = main_v;
  assign out_data  = main_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid/71b, single/71b, skid/8b) against a queue model,
// plus a directed vector table for the skid instance.
module tb_pipe_stage_reg;
  localparam int unsigned W = 71;
  localparam int unsigned N = 3;
`ifdef PIPE_STAGE_CLEAR_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         a_rdy, a_ov, b_rdy, b_ov, c_rdy, c_ov;
  logic [1:0]   a_cnt, b_cnt, c_cnt;
  logic [W-1:0] a_od, b_od;
  logic [7:0]   c_od;

  pipe_stage_reg #(.WIDTH(71), .SKID(1)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
    .in_data(in_data), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .count(a_cnt));
  pipe_stage_reg #(.WIDTH(71), .SKID(0)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
    .in_data(in_data), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .count(b_cnt));
  pipe_stage_reg #(.WIDTH(8), .SKID(1)) u_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_rdy),
    .in_data(in_data[7:0]), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od), .count(c_cnt));

  logic         rdy[N], ov[N];
  logic [1:0]   cnt[N];
  logic [W-1:0] od[N];
  always_comb begin
    rdy[0] = a_rdy; ov[0] = a_ov; cnt[0] = a_cnt; od[0] = a_od;
    rdy[1] = b_rdy; ov[1] = b_ov; cnt[1] = b_cnt; od[1] = b_od;
    rdy[2] = c_rdy; ov[2] = c_ov; cnt[2] = c_cnt; od[2] = W'(c_od);
  end

  // Reference model: each stage is a bounded FIFO of capacity cap[k].
  logic [W-1:0] mq[N][$];
  int           cap[N];
  logic [W-1:0] mask[N];
  bit           m_acc[N], m_pop[N];
  int           total, bad;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         e_rdy;
    logic         e_ov;
    logic [1:0]   e_cnt;
    logic [W-1:0] e_od;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string name, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d at %0t: got %0h want %0h", name, k, $time, act, exp);
    end
  endtask

  function automatic logic m_rdy(input int k);
    if (!reset || flush) return 1'b0;
    if (cap[k] == 2) return (mq[k].size() < 2);
    return (mq[k].size() == 0) || out_ready;
  endfunction

  // Apply inputs just after a falling edge, then check every instance against the model.
  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("in_ready", k, W'(rdy[k]), W'(m_rdy(k)));
      chk("out_valid", k, W'(ov[k]), W'(mq[k].size() > 0));
      chk("count", k, W'(cnt[k]), W'(mq[k].size()));
      if (mq[k].size() > 0) chk("out_data", k, od[k], mq[k][0]);
      else if (ClearEn) chk("out_data_zero", k, od[k], W'(0));
      m_acc[k] = iv && m_rdy(k);
      m_pop[k] = (mq[k].size() > 0) && ordy;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (!reset) begin
        mq[k].delete();
      end else begin
        if (m_pop[k]) void'(mq[k].pop_front());
        if (flush) mq[k].delete();
        else if (m_acc[k]) mq[k].push_back(in_data & mask[k]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    cap[0] = 2; cap[1] = 1; cap[2] = 2;
    mask[0] = '1; mask[1] = '1; mask[2] = W'(8'hFF);
    //            iv   d       ordy  fl    rdy   ov    cnt   od
    tv[0]  = '{1'b1, W'(1),    1'b1, 1'b0, 1'b1, 1'b0, 2'd0, W'(0)};
    tv[1]  = '{1'b1, W'(2),    1'b1, 1'b0, 1'b1, 1'b1, 2'd1, W'(1)};
    tv[2]  = '{1'b1, W'(3),    1'b1, 1'b0, 1'b1, 1'b1, 2'd1, W'(2)};
    tv[3]  = '{1'b0, W'(0),    1'b1, 1'b0, 1'b1, 1'b1, 2'd1, W'(3)};
    tv[4]  = '{1'b1, W'('hA),  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, W'(0)};
    tv[5]  = '{1'b1, W'('hB),  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, W'('hA)};
    tv[6]  = '{1'b1, W'('hC),  1'b0, 1'b0, 1'b0, 1'b1, 2'd2, W'('hA)};
    tv[7]  = '{1'b1, W'('hC),  1'b1, 1'b0, 1'b0, 1'b1, 2'd2, W'('hA)};
    tv[8]  = '{1'b1, W'('hC),  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, W'('hB)};
    tv[9]  = '{1'b0, W'(0),    1'b1, 1'b0, 1'b1, 1'b1, 2'd1, W'('hC)};
    tv[10] = '{1'b1, W'('h11), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, W'(0)};
    tv[11] = '{1'b1, W'('h22), 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, W'('h11)};
    tv[12] = '{1'b1, W'('h55), 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, W'('h11)};
    tv[13] = '{1'b0, W'(0),    1'b1, 1'b0, 1'b1, 1'b0, 2'd0, W'(0)};

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    drive(1'b0, W'(0), 1'b0, 1'b0);
    for (int k = 0; k < N; k++) chk("reset_data", k, od[k], W'(0));
    advance();
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tv[i].iv, tv[i].d, tv[i].ordy, tv[i].fl);
      chk("tbl_in_ready", i, W'(a_rdy), W'(tv[i].e_rdy));
      chk("tbl_out_valid", i, W'(a_ov), W'(tv[i].e_ov));
      chk("tbl_count", i, W'(a_cnt), W'(tv[i].e_cnt));
      if (tv[i].e_ov || ClearEn) chk("tbl_out_data", i, a_od, tv[i].e_od);
      advance();
    end

    // Fill to FULL, then drop reset between edges.
    drive(1'b1, W'('h61), 1'b0, 1'b0); advance();
    drive(1'b1, W'('h62), 1'b0, 1'b0); advance();
    drive(1'b0, W'(0), 1'b0, 1'b0);
    chk("full_before_reset", 0, W'(a_cnt), W'(2));
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("async_out_valid", k, W'(ov[k]), W'(0));
      chk("async_count", k, W'(cnt[k]), W'(0));
      chk("async_out_data", k, od[k], W'(0));
      chk("async_in_ready", k, W'(rdy[k]), W'(0));
      mq[k].delete();
    end
    advance();
    reset = 1'b1;
    drive(1'b1, W'(7), 1'b0, 1'b0); advance();
    drive(1'b0, W'(0), 1'b1, 1'b0);
    chk("first_after_reset", 0, a_od, W'(7));
    chk("first_after_reset_v", 0, W'(a_ov), W'(1));
    advance();

    for (int n = 0; n < 10000; n++) begin
      drive(($urandom % 4) != 0, W'({$urandom, $urandom, $urandom}),
            ($urandom % 3) != 0, ($urandom % 64) == 0);
      advance();
    end
    drive(1'b0, W'(0), 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
